// File: rtl/burst_ram_if.sv
// ---------------------------------------------------------------------------
// burst_ram_if
//
// Command/data bus between the data cache (master) and the burst RAM (slave).
//
// Handshake: there is no ready signal. The master may pulse cmd_en for one
// cycle whenever busy is low; the command, its address and beat 0 of a write
// are taken in that cycle. While busy is high, cmd_en is ignored. Read beats
// are qualified by rd_data_valid alone; rd_data is meaningless when it is low.
//
// Signals
//   cmd           master->slave  0 = read, 1 = write (sampled with cmd_en)
//   cmd_en        master->slave  one-cycle command strobe
//   addr          master->slave  beat address of the first beat
//   wr_data       master->slave  write beat data
//   data_mask     master->slave  per-byte mask, 1 = byte not written
//   rd_data       slave->master  read beat data
//   rd_data_valid slave->master  rd_data holds a valid beat
//   busy          slave->master  command strobes are ignored while high
// ---------------------------------------------------------------------------
interface burst_ram_if #(
    parameter int DATA_BITWIDTH  = 64,
    parameter int DEPTH_BITWIDTH = 8
);
    logic                          cmd;
    logic                          cmd_en;
    logic [DEPTH_BITWIDTH-1:0]     addr;
    logic [DATA_BITWIDTH-1:0]      wr_data;
    logic [DATA_BITWIDTH/8-1:0]    data_mask;
    logic [DATA_BITWIDTH-1:0]      rd_data;
    logic                          rd_data_valid;
    logic                          busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram.sv
// ---------------------------------------------------------------------------
// burst_ram
//
// Burst-oriented RAM standing in for an external DDR/PSRAM controller behind
// the data cache. Each command moves BURST_COUNT consecutive beats starting at
// addr (wrapping modulo the memory size). Reads deliver their first beat
// READ_LATENCY cycles after the command; writes take beat k in cycle T+k.
// After reset the block stays busy for INIT_CYCLES cycles.
//
// Memory is not initialised; contents are undefined until written.
// DATA_FILE is kept as a parameter for interface compatibility only.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (memory is kept)
//   bus          slave modport of burst_ram_if (see interface header)
//   dbg_state_o  out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module burst_ram #(
    parameter int DATA_BITWIDTH  = 64,
    parameter int DEPTH_BITWIDTH = 8,
    parameter int BURST_COUNT    = 4,
    parameter int READ_LATENCY   = 2,
    parameter int INIT_CYCLES    = 10,
    parameter     DATA_FILE      = ""
) (
    input  logic        clk,
    input  logic        rst,
    burst_ram_if.slave  bus,
    output logic [2:0]  dbg_state_o
);
    localparam int BYTES  = DATA_BITWIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_BITWIDTH;
    localparam int BEAT_W = $clog2(BURST_COUNT);
    localparam int WAIT_W = $clog2(READ_LATENCY + 1);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);

    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_IDLE        = 3'd1,
        ST_READ_WAIT   = 3'd2,
        ST_READ_BURST  = 3'd3,
        ST_WRITE_BURST = 3'd4
    } state_t;

    logic [DATA_BITWIDTH-1:0]  mem [DEPTH];

    state_t                    state_q;
    logic [BEAT_W-1:0]         beat_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [INIT_W-1:0]         init_q;
    logic [DEPTH_BITWIDTH-1:0] addr_q;
    logic [DATA_BITWIDTH-1:0]  rd_data_q;
    logic                      rd_valid_q;
    logic                      busy_q;

    logic                      mem_we;
    logic [DEPTH_BITWIDTH-1:0] mem_waddr;
    logic [DEPTH_BITWIDTH-1:0] rd_next_addr;

    // Beat 0 of a write arrives together with cmd_en, so the write port is
    // driven straight from the bus in IDLE and from the latched address
    // afterwards. Reset suppresses any pending beat.
    always_comb begin
        mem_we       = 1'b0;
        mem_waddr    = addr_q + DEPTH_BITWIDTH'(beat_q);
        rd_next_addr = addr_q + DEPTH_BITWIDTH'(beat_q) + DEPTH_BITWIDTH'(1);
        if (!rst) begin
            if (state_q == ST_IDLE && bus.cmd_en && bus.cmd) begin
                mem_we    = 1'b1;
                mem_waddr = bus.addr;
            end else if (state_q == ST_WRITE_BURST) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!bus.data_mask[b]) begin
                    mem[mem_waddr][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Read beats are registered: beat k is fetched on the edge that opens
    // cycle T+READ_LATENCY+k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            beat_q     <= '0;
            wait_q     <= '0;
            init_q     <= '0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_q == INIT_W'(INIT_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        init_q  <= '0;
                    end else begin
                        init_q  <= init_q + INIT_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (bus.cmd_en) begin
                        addr_q <= bus.addr;
                        busy_q <= 1'b1;
                        if (bus.cmd) begin
                            state_q <= ST_WRITE_BURST;
                            beat_q  <= BEAT_W'(1);
                        end else if (READ_LATENCY == 1) begin
                            // No wait cycles: first beat appears next cycle.
                            state_q    <= ST_READ_BURST;
                            beat_q     <= '0;
                            rd_data_q  <= mem[bus.addr];
                            rd_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_READ_WAIT;
                            wait_q  <= '0;
                        end
                    end
                end

                ST_READ_WAIT: begin
                    if (wait_q == WAIT_W'(READ_LATENCY - 2)) begin
                        state_q    <= ST_READ_BURST;
                        beat_q     <= '0;
                        rd_data_q  <= mem[addr_q];
                        rd_valid_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                ST_READ_BURST: begin
                    if (beat_q == BEAT_LAST) begin
                        state_q    <= ST_IDLE;
                        beat_q     <= '0;
                        rd_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        beat_q    <= beat_q + BEAT_W'(1);
                        rd_data_q <= mem[rd_next_addr];
                    end
                end

                ST_WRITE_BURST: begin
                    if (beat_q == BEAT_LAST) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        beat_q  <= beat_q + BEAT_W'(1);
                    end
                end

                default: begin
                    state_q    <= ST_INIT;
                    init_q     <= '0;
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.busy          = busy_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_burst_ram.sv
module tb_burst_ram;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BC = 4;
  localparam int RL = 2;
  localparam int IC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  logic [2:0] init_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: one entry per beat, byte-masked writes applied directly.
  logic [DW-1:0] model_mem [256];

  typedef logic [BC-1:0][DW-1:0] line_t;
  typedef logic [BC-1:0][7:0]    mask_t;

  typedef struct {
    bit        do_wr;
    logic [7:0] addr;
    line_t     wd;
    mask_t     wm;
    line_t     exp;
  } vec_t;

  vec_t vecs [6];

  burst_ram_if #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW)) bus ();

  burst_ram #(
    .DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW), .BURST_COUNT(BC),
    .READ_LATENCY(RL), .INIT_CYCLES(IC), .DATA_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic line_t model_line(input logic [7:0] a);
    line_t l;
    for (int k = 0; k < BC; k++) begin
      logic [7:0] ad;
      ad = a + 8'(k);
      l[k] = model_mem[ad];
    end
    return l;
  endfunction

  // Called in an IDLE cycle; returns in cycle T+BC.
  task automatic do_write(input logic [7:0] a, input line_t d, input mask_t m);
    bus.cmd       = 1'b1;
    bus.cmd_en    = 1'b1;
    bus.addr      = a;
    bus.wr_data   = d[0];
    bus.data_mask = m[0];
    step();
    bus.cmd_en = 1'b0;
    for (int k = 1; k < BC; k++) begin
      check("wr_busy", 64'(bus.busy), 64'd1);
      bus.wr_data   = d[k];
      bus.data_mask = m[k];
      step();
    end
    check("wr_done_busy", 64'(bus.busy), 64'd0);
    for (int k = 0; k < BC; k++) begin
      logic [7:0] ad;
      ad = a + 8'(k);
      for (int b = 0; b < DW / 8; b++) begin
        if (!m[k][b]) model_mem[ad][b*8 +: 8] = d[k][b*8 +: 8];
      end
    end
  endtask

  // Called in an IDLE cycle; returns in cycle T+RL+BC. inject_at > 0 pulses a
  // write strobe at that cycle offset, which must be ignored.
  task automatic do_read(input logic [7:0] a, input line_t exp, input int inject_at);
    bus.cmd    = 1'b0;
    bus.cmd_en = 1'b1;
    bus.addr   = a;
    step();
    bus.cmd_en = 1'b0;
    for (int c = 1; c <= RL + BC; c++) begin
      bit v_exp;
      v_exp = (c >= RL) && (c < RL + BC);
      check("rd_valid", 64'(bus.rd_data_valid), 64'(v_exp));
      if (v_exp) check("rd_data", bus.rd_data, exp[c-RL]);
      check("rd_busy", 64'(bus.busy), 64'(c < RL + BC));
      if (c == inject_at) begin
        bus.cmd       = 1'b1;
        bus.cmd_en    = 1'b1;
        bus.addr      = 8'h10;
        bus.wr_data   = '0;
        bus.data_mask = '0;
      end else begin
        bus.cmd_en = 1'b0;
      end
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    line_t ld;
    mask_t lm;

    bus.cmd = 1'b0; bus.cmd_en = 1'b0; bus.addr = '0;
    bus.wr_data = '0; bus.data_mask = '0;

    // Reset and init window.
    rst = 1'b1;
    step();
    step();
    check("reset_busy", 64'(bus.busy), 64'd1);
    check("reset_valid", 64'(bus.rd_data_valid), 64'd0);
    check("reset_rd_data", bus.rd_data, 64'd0);
    init_state = dbg_state;
    rst = 1'b0;
    for (int i = 0; i < IC; i++) begin
      check("init_busy", 64'(bus.busy), 64'd1);
      step();
    end
    check("init_done_busy", 64'(bus.busy), 64'd0);
    check("left_init", 64'(dbg_state != init_state), 64'd1);

    // Table of write/read vectors with hand-computed read data.
    vecs[0] = '{1'b1, 8'h10,
                {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
                {8'h00, 8'h00, 8'h00, 8'h00},
                {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111}};
    vecs[1] = '{1'b1, 8'h10,
                {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF},
                {8'h00, 8'h00, 8'h00, 8'h00},
                {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}};
    vecs[2] = '{1'b1, 8'h10,
                {64'h0, 64'h0, 64'h0, 64'h0123456789ABCDEF},
                {8'hFF, 8'hFF, 8'hFF, 8'h0F},
                {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h01234567FFFFFFFF}};
    vecs[3] = '{1'b1, 8'h00,
                {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2, 64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0},
                {8'h00, 8'h00, 8'h00, 8'h00},
                {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2, 64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0}};
    vecs[4] = '{1'b1, 8'hFE,
                {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2, 64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0},
                {8'h00, 8'h00, 8'h00, 8'h00},
                {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2, 64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0}};
    vecs[5] = '{1'b0, 8'h00,
                {64'h0, 64'h0, 64'h0, 64'h0},
                {8'h00, 8'h00, 8'h00, 8'h00},
                {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2, 64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2}};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].wd, vecs[i].wm);
      do_read(vecs[i].addr, vecs[i].exp, 0);
    end

    // Command strobe during READ_BURST must be ignored.
    do_read(8'h10, model_line(8'h10), RL + 1);
    do_read(8'h10, model_line(8'h10), 0);

    // Reset on the second valid beat of a read.
    bus.cmd = 1'b0; bus.cmd_en = 1'b1; bus.addr = 8'h10;
    step();
    bus.cmd_en = 1'b0;
    step();
    check("rr_beat0_valid", 64'(bus.rd_data_valid), 64'd1);
    check("rr_beat0_data", bus.rd_data, model_mem[8'h10]);
    step();
    check("rr_beat1_valid", 64'(bus.rd_data_valid), 64'd1);
    check("rr_beat1_data", bus.rd_data, model_mem[8'h11]);
    rst = 1'b1;
    step();
    check("rr_valid_drop", 64'(bus.rd_data_valid), 64'd0);
    check("rr_busy", 64'(bus.busy), 64'd1);
    check("rr_rd_data_zero", bus.rd_data, 64'd0);
    check("rr_state_init", 64'(dbg_state == init_state), 64'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < IC; i++) begin
      check("rr_init_busy", 64'(bus.busy), 64'd1);
      if (i == 3) begin
        bus.cmd = 1'b1; bus.cmd_en = 1'b1; bus.addr = 8'h10;
        bus.wr_data = 64'h0BADC0DE0BADC0DE; bus.data_mask = '0;
      end else begin
        bus.cmd_en = 1'b0;
      end
      step();
    end
    check("rr_init_done", 64'(bus.busy), 64'd0);
    do_read(8'h10, model_line(8'h10), 0);

    // Randomized traffic over a fully written region 0x80..0x9F.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < BC; k++) begin
        ld[k] = {$urandom, $urandom};
        lm[k] = 8'h00;
      end
      do_write(8'h80 + 8'(4 * i), ld, lm);
    end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      a = 8'h80 + 8'($urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BC; k++) begin
          ld[k] = {$urandom, $urandom};
          lm[k] = 8'($urandom_range(0, 255));
        end
        do_write(a, ld, lm);
      end else begin
        do_read(a, model_line(a), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
